// File: rtl/hvac_sequencer.sv
// HVAC sequencer: turns a sampled temperature into heater/aircon/fan enables with
// hysteresis, minimum run time, compressor lockout and fan pre-run/post-run.
module hvac_sequencer #(
  parameter int unsigned HEAT_ON  = 18,
  parameter int unsigned HEAT_OFF = 20,
  parameter int unsigned COOL_ON  = 24,
  parameter int unsigned COOL_OFF = 22,
  parameter int unsigned MIN_ON   = 8,
  parameter int unsigned MIN_OFF  = 8,
  parameter int unsigned FAN_PRE  = 2,
  parameter int unsigned FAN_POST = 4,
  parameter int unsigned CW       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] temperature,
  input  logic       temp_valid,
  input  logic [1:0] mode,
  input  logic       fan_force,
  output logic       heater,
  output logic       aircon,
  output logic       fan,
  output logic [2:0] state,
  output logic       lockout
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_HEAT = 3'd2,
    S_COOL = 3'd3,
    S_POST = 3'd4
  } state_e;

  localparam logic [7:0]    HEAT_ON_T   = 8'(HEAT_ON);
  localparam logic [7:0]    HEAT_OFF_T  = 8'(HEAT_OFF);
  localparam logic [7:0]    COOL_ON_T   = 8'(COOL_ON);
  localparam logic [7:0]    COOL_OFF_T  = 8'(COOL_OFF);
  localparam logic [CW-1:0] MIN_ON_M1   = CW'(MIN_ON - 1);
  localparam logic [CW-1:0] FAN_PRE_M1  = CW'(FAN_PRE - 1);
  localparam logic [CW-1:0] FAN_POST_M1 = CW'(FAN_POST - 1);
  localparam logic [CW-1:0] MIN_OFF_C   = CW'(MIN_OFF);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] off_q, off_d;
  logic          tgt_cool_q, tgt_cool_d;
  logic [7:0]    temp_q;
  logic          seen_q;

  logic          heat_dem, cool_dem;
  logic          heat_done, cool_done;
  logic          run_min;
  logic [CW-1:0] cnt_inc;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      temp_q <= '0;
      seen_q <= 1'b0;
    end else if (temp_valid) begin
      temp_q <= temperature;
      seen_q <= 1'b1;
    end
  end

  assign heat_dem  = seen_q & mode[0] & (temp_q < HEAT_ON_T);
  assign cool_dem  = seen_q & mode[1] & (temp_q > COOL_ON_T);
  assign heat_done = (temp_q >= HEAT_OFF_T) | ~mode[0];
  assign cool_done = (temp_q <= COOL_OFF_T) | ~mode[1];
  assign run_min   = (cnt_q >= MIN_ON_M1);
  assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign lockout   = (off_q != '0);

  // State register, phase counter, off-timer and latched target
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      off_q      <= '0;
      tgt_cool_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      off_q      <= off_d;
      tgt_cool_q <= tgt_cool_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through the
  // case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_inc;
    tgt_cool_d = tgt_cool_q;
    off_d      = lockout ? off_q - 1'b1 : off_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!lockout && (heat_dem || cool_dem)) begin
          tgt_cool_d = ~heat_dem;
          state_d    = S_PRE;
        end
      end
      S_PRE: begin
        // Losing the target's enable aborts the pre-run without a lockout.
        if (tgt_cool_q ? !mode[1] : !mode[0]) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= FAN_PRE_M1) begin
          state_d = tgt_cool_q ? S_COOL : S_HEAT;
          cnt_d   = '0;
        end
      end
      S_HEAT: begin
        if (run_min && heat_done) begin
          state_d = S_POST;
          cnt_d   = '0;
          off_d   = MIN_OFF_C;
        end
      end
      S_COOL: begin
        if (run_min && cool_done) begin
          state_d = S_POST;
          cnt_d   = '0;
          off_d   = MIN_OFF_C;
        end
      end
      S_POST: begin
        if (cnt_q >= FAN_POST_M1) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    heater = (state_q == S_HEAT);
    aircon = (state_q == S_COOL);
    fan    = (state_q != S_IDLE) | fan_force;
    state  = state_q;
  end

endmodule
